// File: rtl/decimal_bcd_pkg.sv
// Shared types for the decimal keypad BCD accumulator.
// Holds the debounce FSM state enum and the key/BCD widths.
package decimal_bcd_pkg;

  localparam int LINES = 10;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

endpackage

// File: rtl/dec_prio_encoder.sv
// Priority encoder for the 10 decimal key lines (highest index wins).
// Ports: d in; code (0..9), any (some key), multi_hot (>1 key) out.
module dec_prio_encoder
  import decimal_bcd_pkg::*;
(
  input  logic [LINES-1:0] d,
  output logic [BCD_W-1:0] code,
  output logic             any,
  output logic             multi_hot
);

  always_comb begin
    code = '0;
    for (int i = 0; i < LINES; i++)
      if (d[i]) code = BCD_W'(i);
  end

  assign any = |d;

  // Clearing the lowest set bit leaves something only if >1 bit set.
  assign multi_hot = |(d & (d - LINES'(1)));

endmodule

// File: rtl/decimal_keypad_bcd_accumulator.sv
// Debounced decimal keypad feeding a shift-in BCD digit register.
// Ports: clk, rst, d[9:0], clr in; bcd_out, digit_cnt, key_valid,
// key_code, full, overflow, multi_hot out.
module decimal_keypad_bcd_accumulator
  import decimal_bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   d,
  input  logic                         clr,
  output logic [4*DIGITS-1:0]          bcd_out,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic                         key_valid,
  output logic [3:0]                   key_code,
  output logic                         full,
  output logic                         overflow,
  output logic                         multi_hot
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [8:0] DB_W = 9'(DEBOUNCE);

  logic [LINES-1:0] d_q;
  logic [BCD_W-1:0] code;
  logic             any;
  logic             mh;
  state_t           state;
  logic [7:0]       cnt;
  logic [BCD_W-1:0] lat;
  logic             accept;

  dec_prio_encoder u_enc (
    .d         (d_q),
    .code      (code),
    .any       (any),
    .multi_hot (mh)
  );

  // Accept on the edge where the stable count would reach DEBOUNCE.
  always_comb begin
    accept = 1'b0;
    unique case (state)
      IDLE:
        accept = any && (DEBOUNCE == 1);
      decimal_bcd_pkg::DEBOUNCE:
        accept = any && (code == lat) &&
                 (({1'b0, cnt} + 9'd1) == DB_W);
      default:
        accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q       <= '0;
      state     <= IDLE;
      cnt       <= '0;
      lat       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      multi_hot <= 1'b0;
    end else begin
      d_q       <= d;
      multi_hot <= mh;
      key_valid <= accept;
      if (accept) key_code <= code;
      unique case (state)
        IDLE: begin
          if (any) begin
            state <= (DEBOUNCE == 1) ?
                     HELD : decimal_bcd_pkg::DEBOUNCE;
            cnt   <= 8'd1;
            lat   <= code;
          end
        end
        decimal_bcd_pkg::DEBOUNCE: begin
          if (!any) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (code != lat) begin
            lat <= code;
            cnt <= 8'd1;
          end else begin
            cnt <= cnt + 8'd1;
            if (accept) state <= HELD;
          end
        end
        HELD: begin
          if (!any) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Digit register: clear beats accept; a full register only flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out   <= '0;
      digit_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (clr) begin
        bcd_out   <= '0;
        digit_cnt <= '0;
      end else if (accept) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          bcd_out   <= W'({bcd_out, code});
          digit_cnt <= digit_cnt + CW'(1);
        end
      end
    end
  end

  assign full = (digit_cnt == CW'(DIGITS));

endmodule

// File: tb/tb_decimal_keypad_bcd_accumulator.sv
// Scoreboard bench for the decimal keypad BCD accumulator.
// A decimal-number model predicts each accepted key; a monitor checks.
module tb_decimal_keypad_bcd_accumulator;

  localparam int DIGITS = 4;
  localparam int DB     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [9:0]  d;
  logic [15:0] bcd_out;
  logic [2:0]  digit_cnt;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        full;
  logic        overflow;
  logic        multi_hot;

  decimal_keypad_bcd_accumulator #(
    .DIGITS   (DIGITS),
    .DEBOUNCE (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .clr       (clr),
    .bcd_out   (bcd_out),
    .digit_cnt (digit_cnt),
    .key_valid (key_valid),
    .key_code  (key_code),
    .full      (full),
    .overflow  (overflow),
    .multi_hot (multi_hot)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         at;
    logic [3:0] code;
    logic [15:0] bcd;
    logic [2:0] cnt;
    logic       ovf;
    logic       mh;
    logic       full;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int passed = 0;
  int mval = 0;
  int mcnt = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s got %0h want %0h", name, act, want);
  endtask

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] top_key(logic [9:0] p);
    logic [3:0] k;
    k = 0;
    for (int i = 0; i < 10; i++) if (p[i]) k = 4'(i);
    return k;
  endfunction

  task automatic model_clear();
    mval = 0;
    mcnt = 0;
  endtask

  task automatic model_accept(logic [9:0] p, bit clr_now, int at);
    exp_t e;
    e.at   = at;
    e.code = top_key(p);
    e.mh   = ($countones(p) > 1);
    e.ovf  = 1'b0;
    if (clr_now) begin
      model_clear();
    end else if (mcnt == DIGITS) begin
      e.ovf = 1'b1;
    end else begin
      mval = (mval * 10 + int'(e.code)) % 10000;
      mcnt++;
    end
    e.bcd  = to_bcd(mval);
    e.cnt  = 3'(mcnt);
    e.full = (mcnt == DIGITS);
    q.push_back(e);
  endtask

  // Called at a negedge: hold p for h samples, then g zero samples.
  task automatic press(logic [9:0] p, int h, int g,
                       bit clr_acc, bit clr_end);
    int start;
    start = cyc;
    if (h <= DB) clr_acc = 0;
    if (h + g - 1 <= DB) clr_end = 0;
    if (h >= DB) model_accept(p, clr_acc, start + 1 + DB);
    for (int i = 0; i < h + g; i++) begin
      d   = (i < h) ? p : 10'h000;
      clr = (clr_acc && i == DB) || (clr_end && i == h + g - 1);
      @(negedge clk);
    end
    clr = 1'b0;
    if (clr_end) model_clear();
  endtask

  task automatic check_state(string tag);
    check({tag, "_bcd"}, 32'(bcd_out), 32'(to_bcd(mval)));
    check({tag, "_cnt"}, 32'(digit_cnt), mcnt);
    check({tag, "_full"}, 32'(full), 32'(mcnt == DIGITS));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_key got code %0h want none",
                   key_code);
        end else begin
          mon_e = q.pop_front();
          check("accept_cycle", cyc, mon_e.at);
          check("key_code", 32'(key_code), 32'(mon_e.code));
          check("bcd_out", 32'(bcd_out), 32'(mon_e.bcd));
          check("digit_cnt", 32'(digit_cnt), 32'(mon_e.cnt));
          check("overflow", 32'(overflow), 32'(mon_e.ovf));
          check("multi_hot", 32'(multi_hot), 32'(mon_e.mh));
          check("full", 32'(full), 32'(mon_e.full));
        end
      end else if (overflow) begin
        checks++;
        $display("FAIL stray_overflow got 1 want 0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    d   = 10'h3ff;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 0);
    check("rst_cnt", 32'(digit_cnt), 0);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_code", 32'(key_code), 0);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_mh", 32'(multi_hot), 0);
    d   = 10'h000;
    rst = 1'b0;
    @(negedge clk);

    press(10'h1 << 1, 5, 3, 0, 0);
    press(10'h1 << 9, 5, 3, 0, 0);
    press(10'h1 << 0, 5, 3, 0, 0);
    press(10'h1 << 5, 5, 3, 0, 0);
    check("seq_1905", 32'(bcd_out), 32'h1905);
    check_state("seq");

    press(10'h010, 2, 3, 0, 0);
    check_state("short");

    press(10'h1 << 2, 5, 3, 0, 0);
    check_state("ovf");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check_state("clr");

    press(10'h088, 5, 3, 0, 0);
    check_state("multi");

    press(10'h1 << 6, 5, 3, 1, 0);
    check_state("clr_acc");

    d = 10'h1 << 4;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_bcd", 32'(bcd_out), 0);
    check("arst_valid", 32'(key_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    model_accept(10'h1 << 4, 0, cyc + 1 + DB);
    repeat (5) @(negedge clk);
    d = 10'h000;
    repeat (3) @(negedge clk);
    check_state("rst_key");

    for (int n = 0; n < 40; n++) begin
      logic [9:0] p;
      if ($urandom_range(1, 0) == 1)
        p = 10'h1 << $urandom_range(9, 0);
      else
        p = 10'($urandom_range(1023, 1));
      press(p, $urandom_range(6, 1), $urandom_range(4, 1),
            $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0);
    end

    repeat (6) @(negedge clk);
    check("pending", q.size(), 0);
    check_state("final");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
